logs_tone_meter: RTL

Frequency-measuring counterpart of the square-wave NCO: it samples an incoming square wave on `step` pulses and counts rising edges over a fixed gate window. It reports the count, which equals the NCO's frequency word scaled by 2^G, through a valid/ready handshake. It is used to close the loop on NCO tone generation and for self-test of the sound path.

---
 rtl/logs_pkg.sv | 18 +
 rtl/logs_edge_sync.sv | 40 ++++
 rtl/logs_tone_meter.sv | 100 ++++++++++
 3 files changed

// File: rtl/logs_pkg.sv
// Shared definitions for the tone meter and its matching square-wave NCO:
// default widths, FSM encoding and the result-width helper.
package logs_pkg;

   localparam int N_DEFAULT = 5;
   localparam int G_DEFAULT = 2;

   // The priming sample is taken on the IDLE exit, so no separate PRIME state is needed.
   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   function automatic int meas_width(input int n, input int g);
      return n + g;
   endfunction

endpackage

// File: rtl/logs_edge_sync.sv
// Optional 2-flop synchroniser on the measured square wave, followed by a
// rising-edge detector whose reference sample only advances on step.
module logs_edge_sync #(
   parameter int SYNC = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic step,
   input  logic snd_in,
   output logic rise
);

   logic level;
   logic prev;

   generate
      if (SYNC != 0) begin : g_sync
         logic [1:0] sync_q;

         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge value regardless of process ordering.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sync_q <= 2'b00;
            else        sync_q <= {sync_q[0], snd_in};
         end

         assign level = sync_q[1];
      end else begin : g_direct
         assign level = snd_in;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    prev <= 1'b0;
      else if (step) prev <= level;
   end

   assign rise = step & level & ~prev;

endmodule

// File: rtl/logs_tone_meter.sv
// Square-wave frequency meter: counts rising edges of snd_in over 2^(N+G)
// step samples and offers the count through a valid/ready handshake.
module logs_tone_meter
   import logs_pkg::*;
#(
   parameter int N    = N_DEFAULT,
   parameter int G    = G_DEFAULT,
   parameter int SYNC = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step,
   input  logic             enable,
   input  logic             snd_in,
   output logic [N+G-1:0]   meas,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic             overrun,
   output logic             locked
);

   localparam int W = meas_width(N, G);

   state_t         state, state_nxt;
   logic [W-1:0]   win;
   logic [W-1:0]   ec;
   logic [W-1:0]   ec_nxt;
   logic [W:0]     diff;
   logic           near;
   logic           have_res;
   logic           rise;
   logic           count_step;
   logic           win_end;

   logs_edge_sync #(.SYNC(SYNC)) u_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .step   (step),
      .snd_in (snd_in),
      .rise   (rise)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (step && enable)    state_nxt = COUNT;
         COUNT:   if (win_end && !enable) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      count_step = (state == COUNT) && step;
      win_end    = count_step && (win == '1);
   end

   // Edge count saturates; the window-ending step's own edge is included in the result.
   assign ec_nxt = (rise && (ec != '1)) ? ec + 1'b1 : ec;
   assign diff   = {1'b0, ec_nxt} - {1'b0, meas};
   assign near   = (diff == '0) || (diff == {{W{1'b0}}, 1'b1}) || (diff == '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win        <= '0;
         ec         <= '0;
         meas       <= '0;
         meas_valid <= 1'b0;
         overrun    <= 1'b0;
         locked     <= 1'b0;
         have_res   <= 1'b0;
      end else begin
         if (count_step) begin
            win <= win + 1'b1;
            ec  <= win_end ? '0 : ec_nxt;
         end
         if (win_end) begin
            meas       <= ec_nxt;
            meas_valid <= 1'b1;
            if (meas_valid && !meas_ready) overrun <= 1'b1;
            // Returning to IDLE forgets the history, so the next first result cannot lock.
            if (enable) begin
               locked   <= have_res && near;
               have_res <= 1'b1;
            end else begin
               locked   <= 1'b0;
               have_res <= 1'b0;
            end
         end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
         end
      end
   end

endmodule
